md_sequencer: RTL and testbench
===============================

# md_sequencer

Multicycle multiply/divide sequencer for the CPU datapath. It takes the two operands held in registers A and B, runs a 32-step signed Booth multiply or signed restoring divide, and produces the 64-bit result as HI/LO words together with a one-cycle write strobe for the HI and LO registers. It sits beside the ALU and is started and stalled by `unid_controle`. It also reports divide-by-zero so the control unit can take the ConstDiv0 exception path.

## Interface
- `WIDTH`, default 32: operand and result-word width. Must be a power of two, at least 8.

- `clock`, in, 1: single clock; all state changes on the rising edge.
- `reset`, in, 1: synchronous, active-low reset.
- `start_mult`, in, 1: request a signed multiply. Sampled only in IDLE.
- `start_div`, in, 1: request a signed divide. Sampled only in IDLE.
- `op_a`, in, WIDTH: multiplicand or dividend. Sampled on the start edge.
- `op_b`, in, WIDTH: multiplier or divisor. Sampled on the start edge.
- `busy`, out, 1: high in RUN and DONE.
- `done`, out, 1: one-cycle completion pulse.
- `hi_lo_write`, out, 1: one-cycle HI/LO load strobe. High in the same cycle as `done`, only on a successful result.
- `hi_out`, out, WIDTH: product upper word, or remainder.
- `lo_out`, out, WIDTH: product lower word, or quotient.
- `div_zero`, out, 1: high together with `done` when the divisor was 0.

## Operation
- **States:** IDLE, RUN, DONE.
- **IDLE**
  - `start_mult` high: latch the operands, set op = MULT, clear the counter, go to RUN.
  - `start_div` high: latch the operands, set op = DIV, clear the counter, go to RUN.
  - `start_mult` and `start_div` both high: multiply wins; the divide request is dropped.
  - `start_div` with `op_b` = 0: go directly to DONE with `div_zero` = 1. No iterations run.
- **RUN:** one iteration per cycle. The counter counts 0..WIDTH-1; after iteration WIDTH-1 the block goes to DONE.
- **DONE:** `done` = 1. `hi_out`/`lo_out` are loaded from the working registers (except on divide-by-zero). `hi_lo_write` = ~`div_zero`. The next state is always IDLE.
- **Start pulses while `busy`:** ignored. They are not queued.
- **Multiply:** radix-2 Booth over a 2·WIDTH+1-bit accumulator {P_hi, P_lo, q₋₁}.
  - Each step adds −A, +A or 0 to P_hi based on {P_lo[0], q₋₁}.
  - The add is WIDTH+1 bits wide so the A = −2^(WIDTH−1) case cannot overflow.
  - Each step ends with an arithmetic right shift.
  - The result is the full signed 2·WIDTH-bit product: HI = upper word, LO = lower word.
- **Divide:** restoring division on magnitudes, followed by sign fix-up.
  - Quotient sign = sign(a) XOR sign(b). Quotient truncates toward zero.
  - Remainder takes the sign of the dividend.
  - −2^(WIDTH−1) / −1 gives LO = 0x80000000 and HI = 0. No trap is raised.
- **Output holding:** `hi_out` and `lo_out` change only in DONE on a successful result; otherwise they hold their value.
- **Reset:** `reset` low at any clock edge, including mid-operation, aborts the operation.
  - State returns to IDLE.
  - All outputs become 0, the counter becomes 0 and the working registers are cleared.

## Timing
- Let the start edge be k.
- **Normal operation:**
  - RUN covers edges k+1 … k+WIDTH.
  - DONE is entered at edge k+WIDTH+1. For WIDTH = 32, `done` is high during cycle 33 after the start.
  - The block is back in IDLE one cycle later, so the next start is accepted at edge k+WIDTH+2.
- **Divide-by-zero:** `done` and `div_zero` are high in the cycle after edge k+1. `hi_lo_write` = 0.
- **Reset values:** `busy`, `done`, `hi_lo_write`, `div_zero` = 0; `hi_out`, `lo_out` = 0.
- **Output registration:** all outputs are registered, with no combinational path from inputs to outputs.

## Configuration
- `MD_DIV_EN` defined:
  - The divider path, the DIV operation and the `div_zero` logic are compiled in.
- `MD_DIV_EN` not defined:
  - Only multiply is built.
  - `start_div` is ignored, so IDLE stays IDLE and `busy`/`done` stay 0.
  - `div_zero` is tied to 0.
  - The divide working registers are removed.

## Structure
- **Shared package `md_pkg`:**
  - State enum (IDLE/RUN/DONE).
  - Op enum (MULT/DIV).
  - `MD_WIDTH` = 32.
  - Counter width = clog2(WIDTH).
- **Sub-module `md_iter_step`:** one combinational iteration.
  - Booth add/shift, or the restoring subtract/select.
  - Selected by op.
  - Instantiated once inside the sequencer.
- **Sequencer:** holds the FSM, the counter, the operand, accumulator and sign registers, and the output registers.

## Test plan
- Multiply 7 × −3 (0xFFFFFFFD) → at cycle k+33: `done` = 1, `hi_lo_write` = 1, HI = 0xFFFFFFFF, LO = 0xFFFFFFEB.
- Multiply 0x80000000 × 0x80000000 → HI = 0x40000000, LO = 0x00000000. Same-cycle `start_div` is ignored (mult priority).
- Divide −7 / 2 → LO = 0xFFFFFFFD (−3), HI = 0xFFFFFFFF (−1). Divide 0x80000000 / 0xFFFFFFFF → LO = 0x80000000, HI = 0.
- Divide 5 / 0 with HI/LO previously 0x11/0x22 → `done` and `div_zero` at k+1, `hi_lo_write` = 0, HI/LO remain 0x11/0x22.
- Start a multiply, pulse `start_mult` during iteration 5, then drive `reset` low at iteration 10:
  - The extra start is ignored.
  - After the reset edge, `busy` = 0 and all outputs = 0.
  - A new 2 × 3 multiply then gives LO = 6.
- Build without `MD_DIV_EN`, pulse `start_div` with 6 / 3 → `busy` stays 0 for 40 cycles and no `done` occurs. Multiply still passes.

Source files
------------

// File: rtl/md_pkg.sv
// md_pkg: shared types and sizing for the multiply/divide sequencer.
package md_pkg;
  localparam int MD_WIDTH = 32;
  typedef enum logic [1:0] {IDLE, RUN, DONE} mdState;
  typedef enum logic {MULT, DIV} mdOp;
  function automatic int cntWidth(input int w);
    return $clog2(w);
  endfunction
  localparam int MD_CNT_W = cntWidth(MD_WIDTH);
endpackage

// File: rtl/md_iter_step.sv
// md_iter_step: one combinational Booth multiply or restoring divide iteration.
module md_iter_step
  import md_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  mdOp              op,
  input  logic [WIDTH-1:0] regA,
  input  logic [WIDTH-1:0] accHi,
  input  logic [WIDTH-1:0] accLo,
  input  logic             qm1,
  output logic [WIDTH-1:0] nextHi,
  output logic [WIDTH-1:0] nextLo,
  output logic             nextQm1
);
  logic [WIDTH:0] hiExt, aExt, boothSum, trial;
  logic [WIDTH-1:0] shifted;
  always_comb begin
    hiExt = {accHi[WIDTH-1], accHi};
    aExt = {regA[WIDTH-1], regA};
    boothSum = ({accLo[0], qm1} == 2'b01) ? hiExt + aExt : ({accLo[0], qm1} == 2'b10) ? hiExt - aExt : hiExt;
    // the divide remainder stays below the divisor magnitude, so its top bit is always 0
    shifted = {accHi[WIDTH-2:0], accLo[WIDTH-1]};
    trial = {1'b0, shifted} - {1'b0, regA};
    nextHi = (op == MULT) ? boothSum[WIDTH:1] : trial[WIDTH] ? shifted : trial[WIDTH-1:0];
    nextLo = (op == MULT) ? {boothSum[0], accLo[WIDTH-1:1]} : {accLo[WIDTH-2:0], ~trial[WIDTH]};
    nextQm1 = (op == MULT) && accLo[0];
  end
endmodule

// File: rtl/md_sequencer.sv
// md_sequencer: multicycle signed Booth multiply / restoring divide sequencer producing HI/LO.
// Divide support (DIV op, sign fix-up, div_zero) is built only when MD_DIV_EN is defined.
module md_sequencer
  import md_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start_mult,
  input  logic             start_div,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic             hi_lo_write,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out,
  output logic             div_zero
);
  localparam int CW = cntWidth(WIDTH);
  mdState state, nextState;
  mdOp op;
  logic [WIDTH-1:0] regA, accHi, accLo, stepHi, stepLo, resHi, resLo, absA, absB;
  logic qm1, stepQm1, lastIter, startDiv, divZeroHit;
  logic [CW-1:0] cnt;
  assign lastIter = cnt == CW'(WIDTH - 1);
`ifdef MD_DIV_EN
  logic qNeg, remNeg;
  assign startDiv = start_div;
  assign absA = op_a[WIDTH-1] ? -op_a : op_a;
  assign absB = op_b[WIDTH-1] ? -op_b : op_b;
  assign resHi = (op == DIV && remNeg) ? -accHi : accHi;
  assign resLo = (op == DIV && qNeg) ? -accLo : accLo;
  always_ff @(posedge clock) begin
    if (!reset) begin
      op <= MULT;
      qNeg <= 1'b0;
      remNeg <= 1'b0;
      divZeroHit <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      div_zero <= state == DONE && divZeroHit;
      if (state == IDLE && (start_mult || start_div)) begin
        op <= start_mult ? MULT : DIV;
        qNeg <= op_a[WIDTH-1] ^ op_b[WIDTH-1];
        remNeg <= op_a[WIDTH-1];
        divZeroHit <= !start_mult && op_b == '0;
      end
    end
  end
`else
  logic unusedStartDiv;
  assign unusedStartDiv = start_div;
  assign startDiv = 1'b0;
  assign op = MULT;
  assign divZeroHit = 1'b0;
  assign div_zero = 1'b0;
  assign absA = '0;
  assign absB = '0;
  assign resHi = accHi;
  assign resLo = accLo;
`endif
  md_iter_step #(.WIDTH(WIDTH)) step (
    .op(op), .regA(regA), .accHi(accHi), .accLo(accLo), .qm1(qm1),
    .nextHi(stepHi), .nextLo(stepLo), .nextQm1(stepQm1)
  );
  always_comb begin
    nextState = IDLE;
    if (state == IDLE) nextState = start_mult ? RUN : !startDiv ? IDLE : (op_b == '0) ? DONE : RUN;
    else if (state == RUN) nextState = lastIter ? DONE : RUN;
  end
  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= IDLE;
      cnt <= '0;
      regA <= '0;
      accHi <= '0;
      accLo <= '0;
      qm1 <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      hi_lo_write <= 1'b0;
      hi_out <= '0;
      lo_out <= '0;
    end else begin
      state <= nextState;
      busy <= nextState != IDLE;
      done <= state == DONE;
      hi_lo_write <= state == DONE && !divZeroHit;
      if (state == DONE && !divZeroHit) begin
        hi_out <= resHi;
        lo_out <= resLo;
      end
      if (state == IDLE && start_mult) begin
        regA <= op_a;
        accHi <= '0;
        accLo <= op_b;
        qm1 <= 1'b0;
        cnt <= '0;
      end else if (state == IDLE && startDiv) begin
        regA <= absB;
        accHi <= '0;
        accLo <= absA;
        qm1 <= 1'b0;
        cnt <= '0;
      end else if (state == RUN) begin
        accHi <= stepHi;
        accLo <= stepLo;
        qm1 <= stepQm1;
        cnt <= cnt + CW'(1);
      end
    end
  end
endmodule

// File: tb/tb_md_sequencer.sv
// tb_md_sequencer: randomized self-checking bench for md_sequencer against a behavioural arithmetic model.
// Divide scenarios run when MD_DIV_EN is defined; otherwise divide requests are checked to be ignored.
module tb_md_sequencer;
  localparam int W = 32;
  logic clock = 1'b0;
  logic reset = 1'b0;
  logic start_mult = 1'b0;
  logic start_div = 1'b0;
  logic [W-1:0] op_a = '0;
  logic [W-1:0] op_b = '0;
  logic busy, done, hi_lo_write, div_zero;
  logic [W-1:0] hi_out, lo_out;
  int nChecks = 0;
  int nFails = 0;

  md_sequencer #(.WIDTH(W)) dut (
    .clock(clock), .reset(reset), .start_mult(start_mult), .start_div(start_div),
    .op_a(op_a), .op_b(op_b), .busy(busy), .done(done), .hi_lo_write(hi_lo_write),
    .hi_out(hi_out), .lo_out(lo_out), .div_zero(div_zero)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  function automatic logic [2*W-1:0] mulRef(input logic [W-1:0] a, input logic [W-1:0] b);
    longint p;
    p = longint'($signed(a)) * longint'($signed(b));
    return p;
  endfunction

  function automatic logic [2*W-1:0] divRef(input logic [W-1:0] a, input logic [W-1:0] b);
    longint x, y, q, r;
    x = longint'($signed(a));
    y = longint'($signed(b));
    q = x / y;
    r = x % y;
    return {r[W-1:0], q[W-1:0]};
  endfunction

  function automatic logic [W-1:0] pick();
    int sel;
    sel = $urandom_range(0, 6);
    if (sel == 0) return 32'h80000000;
    if (sel == 1) return 32'hFFFFFFFF;
    if (sel == 2) return 32'h7FFFFFFF;
    if (sel == 3) return 32'h00000001;
    return $urandom;
  endfunction

  // Starts one operation and waits (bounded) for done; lat counts edges from the start edge.
  task automatic doOp(input logic m, input logic d, input logic noWait, input logic [W-1:0] a,
                      input logic [W-1:0] b, output int lat, output logic bsy,
                      output logic [W-1:0] hi, output logic [W-1:0] lo, output logic hlw, output logic dz);
    if (!noWait) @(negedge clock);
    start_mult = m;
    start_div = d;
    op_a = a;
    op_b = b;
    @(posedge clock);
    #1;
    start_mult = 1'b0;
    start_div = 1'b0;
    op_a = $urandom;
    op_b = $urandom;
    lat = -1;
    bsy = 1'b0;
    hi = '0;
    lo = '0;
    hlw = 1'b0;
    dz = 1'b0;
    for (int i = 1; i <= 100 && lat < 0; i++) begin
      @(negedge clock);
      if (i == 1) bsy = busy;
      if (done) begin
        lat = i - 1;
        hi = hi_out;
        lo = lo_out;
        hlw = hi_lo_write;
        dz = div_zero;
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    nChecks++;
    if ({busy, done, hi_lo_write, div_zero, hi_out, lo_out} !== '0) begin
      nFails++;
      $display("FAIL reset_state: busy=%b done=%b hlw=%b dz=%b hi=%h lo=%h, expected all zero",
               busy, done, hi_lo_write, div_zero, hi_out, lo_out);
    end
    reset = 1'b1;
  endtask

  task automatic test_mult;
    logic [W-1:0] a, b, hi, lo;
    logic [2*W-1:0] exp;
    logic bsy, hlw, dz;
    int lat;
    for (int i = 0; i < 14; i++) begin
      a = (i == 0) ? 32'd7 : pick();
      b = (i == 0) ? 32'hFFFFFFFD : pick();
      exp = mulRef(a, b);
      doOp(1'b1, 1'b0, 1'b0, a, b, lat, bsy, hi, lo, hlw, dz);
      nChecks++;
      if (lat != W + 1 || bsy !== 1'b1) begin
        nFails++;
        $display("FAIL mult_timing %h*%h: latency=%0d busy=%b, expected latency=%0d busy=1", a, b, lat, bsy, W + 1);
      end
      nChecks++;
      if ({hi, lo} !== exp) begin
        nFails++;
        $display("FAIL mult_result %h*%h: got %h_%h, expected %h", a, b, hi, lo, exp);
      end
      nChecks++;
      if ({hlw, dz} !== 2'b10) begin
        nFails++;
        $display("FAIL mult_strobe %h*%h: hlw=%b dz=%b, expected hlw=1 dz=0", a, b, hlw, dz);
      end
    end
    @(negedge clock);
    nChecks++;
    if ({done, hi_lo_write} !== 2'b00) begin
      nFails++;
      $display("FAIL mult_pulse_width: done=%b hlw=%b one cycle later, expected 0 0", done, hi_lo_write);
    end
  endtask

  task automatic test_mult_priority;
    logic [W-1:0] hi, lo;
    logic bsy, hlw, dz;
    int lat;
    doOp(1'b1, 1'b1, 1'b0, 32'h80000000, 32'h80000000, lat, bsy, hi, lo, hlw, dz);
    nChecks++;
    if (lat != W + 1 || {hi, lo} !== 64'h40000000_00000000 || {hlw, dz} !== 2'b10) begin
      nFails++;
      $display("FAIL mult_priority: latency=%0d hi=%h lo=%h hlw=%b dz=%b, expected %0d 40000000 00000000 1 0",
               lat, hi, lo, hlw, dz, W + 1);
    end
  endtask

  task automatic test_back_to_back;
    logic [W-1:0] a, b, hi, lo;
    logic bsy, hlw, dz;
    int lat;
    for (int i = 0; i < 3; i++) begin
      a = $urandom;
      b = $urandom;
      doOp(1'b1, 1'b0, i != 0, a, b, lat, bsy, hi, lo, hlw, dz);
      nChecks++;
      if (lat != W + 1 || {hi, lo} !== mulRef(a, b)) begin
        nFails++;
        $display("FAIL back_to_back[%0d]: latency=%0d result=%h_%h, expected %0d %h", i, lat, hi, lo, W + 1, mulRef(a, b));
      end
    end
  endtask

  task automatic test_ignore_start;
    logic [W-1:0] a, b;
    int lat;
    a = $urandom;
    b = $urandom;
    lat = -1;
    @(negedge clock);
    start_mult = 1'b1;
    op_a = a;
    op_b = b;
    @(posedge clock);
    #1;
    start_mult = 1'b0;
    repeat (5) @(posedge clock);
    #1;
    start_mult = 1'b1;
    op_a = ~a;
    op_b = b + 32'd1;
    @(posedge clock);
    #1;
    start_mult = 1'b0;
    for (int i = 1; i <= 100 && lat < 0; i++) begin
      @(negedge clock);
      if (done) lat = i + 5;
    end
    nChecks++;
    if (lat != W + 1 || {hi_out, lo_out} !== mulRef(a, b)) begin
      nFails++;
      $display("FAIL ignore_start: latency=%0d result=%h_%h, expected %0d %h", lat, hi_out, lo_out, W + 1, mulRef(a, b));
    end
  endtask

  task automatic test_abort;
    logic [W-1:0] hi, lo;
    logic bsy, hlw, dz, sawActive;
    int lat;
    doOp(1'b1, 1'b0, 1'b0, 32'h1234, 32'h5678, lat, bsy, hi, lo, hlw, dz);
    @(negedge clock);
    start_mult = 1'b1;
    op_a = 32'd100;
    op_b = 32'd200;
    @(posedge clock);
    #1;
    start_mult = 1'b0;
    repeat (10) @(posedge clock);
    #1;
    reset = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b1;
    nChecks++;
    if ({busy, done, hi_lo_write, div_zero, hi_out, lo_out} !== '0) begin
      nFails++;
      $display("FAIL abort_outputs: busy=%b done=%b hlw=%b dz=%b hi=%h lo=%h, expected all zero",
               busy, done, hi_lo_write, div_zero, hi_out, lo_out);
    end
    sawActive = 1'b0;
    repeat (40) begin
      @(negedge clock);
      sawActive |= busy | done;
    end
    nChecks++;
    if (sawActive !== 1'b0) begin
      nFails++;
      $display("FAIL abort_idle: busy/done seen=%b after abort, expected 0", sawActive);
    end
    doOp(1'b1, 1'b0, 1'b0, 32'd2, 32'd3, lat, bsy, hi, lo, hlw, dz);
    nChecks++;
    if (lat != W + 1 || hi !== 32'd0 || lo !== 32'd6 || hlw !== 1'b1) begin
      nFails++;
      $display("FAIL abort_restart: latency=%0d hi=%h lo=%h hlw=%b, expected %0d 0 6 1", lat, hi, lo, hlw, W + 1);
    end
  endtask

`ifdef MD_DIV_EN
  task automatic test_div;
    logic [W-1:0] a, b, hi, lo;
    logic [2*W-1:0] exp;
    logic bsy, hlw, dz;
    int lat;
    for (int i = 0; i < 16; i++) begin
      a = (i == 0) ? 32'hFFFFFFF9 : (i == 1) ? 32'h80000000 : (i == 15) ? 32'h451 : pick();
      b = (i == 0) ? 32'd2 : (i == 1) ? 32'hFFFFFFFF : (i == 15) ? 32'h20 : pick();
      if (i >= 2 && i < 8) b = (i % 2 == 1) ? -32'($urandom_range(1, 17)) : 32'($urandom_range(1, 17));
      if (b == '0) b = 32'd3;
      exp = divRef(a, b);
      doOp(1'b0, 1'b1, 1'b0, a, b, lat, bsy, hi, lo, hlw, dz);
      nChecks++;
      if (lat != W + 1 || bsy !== 1'b1) begin
        nFails++;
        $display("FAIL div_timing %h/%h: latency=%0d busy=%b, expected latency=%0d busy=1", a, b, lat, bsy, W + 1);
      end
      nChecks++;
      if ({hi, lo} !== exp) begin
        nFails++;
        $display("FAIL div_result %h/%h: got rem=%h quo=%h, expected %h", a, b, hi, lo, exp);
      end
      nChecks++;
      if ({hlw, dz} !== 2'b10) begin
        nFails++;
        $display("FAIL div_strobe %h/%h: hlw=%b dz=%b, expected hlw=1 dz=0", a, b, hlw, dz);
      end
    end
  endtask

  task automatic test_div_zero;
    logic [W-1:0] hi, lo;
    logic bsy, hlw, dz;
    int lat;
    doOp(1'b0, 1'b1, 1'b0, 32'd5, 32'd0, lat, bsy, hi, lo, hlw, dz);
    nChecks++;
    if (lat != 1 || {dz, hlw} !== 2'b10) begin
      nFails++;
      $display("FAIL div_zero_flags: latency=%0d dz=%b hlw=%b, expected 1 1 0", lat, dz, hlw);
    end
    nChecks++;
    if (hi !== 32'h11 || lo !== 32'h22) begin
      nFails++;
      $display("FAIL div_zero_hold: hi=%h lo=%h, expected 00000011 00000022", hi, lo);
    end
    @(negedge clock);
    nChecks++;
    if ({done, div_zero, busy} !== 3'b000) begin
      nFails++;
      $display("FAIL div_zero_pulse: done=%b dz=%b busy=%b next cycle, expected 0 0 0", done, div_zero, busy);
    end
  endtask
`else
  task automatic test_div_disabled;
    logic sawBusy, sawDone;
    sawBusy = 1'b0;
    sawDone = 1'b0;
    @(negedge clock);
    start_div = 1'b1;
    op_a = 32'd6;
    op_b = 32'd3;
    @(negedge clock);
    start_div = 1'b0;
    sawBusy |= busy;
    repeat (40) begin
      @(negedge clock);
      sawBusy |= busy;
      sawDone |= done;
    end
    nChecks++;
    if (sawBusy !== 1'b0) begin
      nFails++;
      $display("FAIL div_disabled_busy: busy seen=%b, expected 0", sawBusy);
    end
    nChecks++;
    if (sawDone !== 1'b0 || div_zero !== 1'b0) begin
      nFails++;
      $display("FAIL div_disabled_done: done seen=%b dz=%b, expected 0 0", sawDone, div_zero);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_mult();
    test_mult_priority();
    test_back_to_back();
    test_ignore_start();
`ifdef MD_DIV_EN
    test_div();
    test_div_zero();
`else
    test_div_disabled();
`endif
    test_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end
endmodule
